// File: rtl/sid_pkg.sv
// -----------------------------------------------------------------------------
// sid_pkg
// Shared definitions for the SID voice-path schedulers.
//   SID_WAVE_W / SID_ENV_W / SID_OUT_W : default waveform, envelope and
//                                        scaled-output widths
//   sched_state_t                      : scheduler FSM states
//   prod_slice_hi / prod_slice_lo      : bit bounds of the output slice taken
//                                        from a full-width wave*env product
// -----------------------------------------------------------------------------
package sid_pkg;

   localparam int SID_WAVE_W = 12;
   localparam int SID_ENV_W  = 8;
   localparam int SID_OUT_W  = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   // Top bit of the product: the output slice always keeps the MSBs.
   function automatic int prod_slice_hi(input int wave_w, input int env_w);
      return wave_w + env_w - 1;
   endfunction

   // Bottom bit of the product slice; lower bits are truncated, not rounded.
   function automatic int prod_slice_lo(input int wave_w, input int env_w,
                                        input int out_w);
      return wave_w + env_w - out_w;
   endfunction

endpackage

// File: rtl/sid_dca_sched_if.sv
// -----------------------------------------------------------------------------
// sid_dca_sched_if
// Bundles the sample strobe, packed voice inputs and packed scaled outputs
// of the DCA scheduler.
//   master : the voice generators / controller side (drives strobe + data)
//   slave  : the scheduler itself
// Signals:
//   ce_1m       sample strobe, starts one scheduling pass
//   wave_in     packed waveforms, voice 0 in the LSBs
//   env_in      packed envelopes, voice 0 in the LSBs
//   voice_mask  1 = force that voice's output to 0
//   signal_out  packed scaled voices
//   done        one-cycle pulse when signal_out was just updated
//   busy        pass in progress
//   overrun     sticky: strobe arrived while busy
// -----------------------------------------------------------------------------
interface sid_dca_sched_if
   import sid_pkg::*;
#(
   parameter int VOICES = 3,
   parameter int WAVE_W = SID_WAVE_W,
   parameter int ENV_W  = SID_ENV_W,
   parameter int OUT_W  = SID_OUT_W
);

   logic                     ce_1m;
   logic [VOICES*WAVE_W-1:0] wave_in;
   logic [VOICES*ENV_W-1:0]  env_in;
   logic [VOICES-1:0]        voice_mask;
   logic [VOICES*OUT_W-1:0]  signal_out;
   logic                     done;
   logic                     busy;
   logic                     overrun;

   modport master (
      output ce_1m, wave_in, env_in, voice_mask,
      input  signal_out, done, busy, overrun
   );

   modport slave (
      input  ce_1m, wave_in, env_in, voice_mask,
      output signal_out, done, busy, overrun
   );

endinterface

// File: rtl/sid_mul_u12x8.sv
// -----------------------------------------------------------------------------
// sid_mul_u12x8
// Registered unsigned A_W x B_W multiplier with a valid/tag side channel,
// one cycle of latency. Shared by time-multiplexed schedulers.
//   clock, reset : system clock, synchronous active-high reset
//   i_valid      : operands present this cycle
//   i_a, i_b     : unsigned operands
//   i_tag        : caller's identifier, returned alongside the product
//   o_valid      : registered i_valid
//   o_prod       : full-width product, updated only when i_valid was high
//   o_tag        : tag that accompanied the product
// -----------------------------------------------------------------------------
module sid_mul_u12x8
   import sid_pkg::*;
#(
   parameter int A_W   = SID_WAVE_W,
   parameter int B_W   = SID_ENV_W,
   parameter int TAG_W = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 i_valid,
   input  logic [A_W-1:0]       i_a,
   input  logic [B_W-1:0]       i_b,
   input  logic [TAG_W-1:0]     i_tag,
   output logic                 o_valid,
   output logic [A_W+B_W-1:0]   o_prod,
   output logic [TAG_W-1:0]     o_tag
);

   logic                 r_valid;
   logic [A_W+B_W-1:0]   r_prod;
   logic [TAG_W-1:0]     r_tag;
   logic [A_W+B_W-1:0]   w_a_ext;
   logic [A_W+B_W-1:0]   w_b_ext;

   // Zero-extend both operands so the product is computed at full width.
   always_comb begin
      w_a_ext = {{B_W{1'b0}}, i_a};
      w_b_ext = {{A_W{1'b0}}, i_b};
   end

   // Product/tag register; holds its value when no operands are issued.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_prod  <= {(A_W+B_W){1'b0}};
         r_tag   <= {TAG_W{1'b0}};
      end else begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_prod <= w_a_ext * w_b_ext;
            r_tag  <= i_tag;
         end else begin
            r_prod <= r_prod;
            r_tag  <= r_tag;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_prod  = r_prod;
   assign o_tag   = r_tag;

endmodule

// File: rtl/sid_dca_sched.sv
// -----------------------------------------------------------------------------
// sid_dca_sched
// Time-multiplexed DCA for the SID voice path: one shared multiplier scales
// every voice's waveform by its envelope. A ce_1m strobe snapshots all
// inputs, then one voice is issued per fast clock; the scaled voices are
// collected in a shadow bank and published together with a done pulse.
//   clock, reset : fast system clock, synchronous active-high reset
//   bus (slave)  : ce_1m, wave_in, env_in, voice_mask in;
//                  signal_out, done, busy, overrun out
// Latency: ce_1m sampled at edge E -> done high in the cycle after edge
// E+VOICES+1. busy is high from E until the edge that raises done.
// -----------------------------------------------------------------------------
module sid_dca_sched
   import sid_pkg::*;
#(
   parameter int VOICES = 3,
   parameter int WAVE_W = SID_WAVE_W,
   parameter int ENV_W  = SID_ENV_W,
   parameter int OUT_W  = SID_OUT_W
) (
   input  logic            clock,
   input  logic            reset,
   sid_dca_sched_if.slave  bus
);

   localparam int IDX_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int PROD_W   = WAVE_W + ENV_W;
   localparam int SLICE_HI = prod_slice_hi(WAVE_W, ENV_W);
   localparam int SLICE_LO = prod_slice_lo(WAVE_W, ENV_W, OUT_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

   // Scheduler state and snapshots
   sched_state_t            r_state;
   logic [IDX_W-1:0]        r_idx;
   logic [WAVE_W-1:0]       r_snap_wave [VOICES];
   logic [ENV_W-1:0]        r_snap_env  [VOICES];
   logic [VOICES-1:0]       r_snap_mask;
   logic [OUT_W-1:0]        r_shadow    [VOICES];
   logic [VOICES*OUT_W-1:0] r_signal_out;
   logic                    r_done;
   logic                    r_busy;
   logic                    r_overrun;

   // Multiplier interface
   logic                    w_issue;
   logic [WAVE_W-1:0]       w_mul_a;
   logic [ENV_W-1:0]        w_mul_b;
   logic                    w_pvalid;
   logic [PROD_W-1:0]       w_prod;
   logic [IDX_W-1:0]        w_ptag;

   // Write stage
   logic [OUT_W-1:0]        w_wr_val;
   logic                    w_last_wr;
   logic [OUT_W-1:0]        w_merged [VOICES];
   logic [VOICES*OUT_W-1:0] w_merged_flat;

   // Issue side: one snapshot voice per RUN cycle feeds the multiplier.
   always_comb begin
      w_issue = (r_state == RUN);
      w_mul_a = r_snap_wave[r_idx];
      w_mul_b = r_snap_env[r_idx];
   end

   sid_mul_u12x8 #(
      .A_W   (WAVE_W),
      .B_W   (ENV_W),
      .TAG_W (IDX_W)
   ) u_mul (
      .clock   (clock),
      .reset   (reset),
      .i_valid (w_issue),
      .i_a     (w_mul_a),
      .i_b     (w_mul_b),
      .i_tag   (r_idx),
      .o_valid (w_pvalid),
      .o_prod  (w_prod),
      .o_tag   (w_ptag)
   );

   // Write value: truncated product MSBs, or zero for a masked voice.
   always_comb begin
      if (r_snap_mask[w_ptag]) begin
         w_wr_val = {OUT_W{1'b0}};
      end else begin
         w_wr_val = w_prod[SLICE_HI:SLICE_LO];
      end
      w_last_wr = w_pvalid && (w_ptag == LAST_IDX);
   end

   // Shadow bank with the incoming value merged in, so the final voice's
   // result reaches signal_out in the same edge as its shadow write.
   always_comb begin
      w_merged_flat = {(VOICES*OUT_W){1'b0}};
      for (int v = 0; v < VOICES; v++) begin
         if (w_pvalid && (w_ptag == IDX_W'(v))) begin
            w_merged[v] = w_wr_val;
         end else begin
            w_merged[v] = r_shadow[v];
         end
         w_merged_flat[v*OUT_W +: OUT_W] = w_merged[v];
      end
   end

   // Scheduler FSM, snapshot capture, write stage and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= IDLE;
         r_idx        <= {IDX_W{1'b0}};
         r_snap_mask  <= {VOICES{1'b0}};
         r_signal_out <= {(VOICES*OUT_W){1'b0}};
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
         for (int v = 0; v < VOICES; v++) begin
            r_snap_wave[v] <= {WAVE_W{1'b0}};
            r_snap_env[v]  <= {ENV_W{1'b0}};
            r_shadow[v]    <= {OUT_W{1'b0}};
         end
      end else begin
         r_done <= 1'b0;

         // A strobe during a pass is dropped but remembered until reset.
         if (bus.ce_1m && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end else begin
            r_overrun <= r_overrun;
         end

         case (r_state)
            IDLE: begin
               if (bus.ce_1m) begin
                  for (int v = 0; v < VOICES; v++) begin
                     r_snap_wave[v] <= bus.wave_in[v*WAVE_W +: WAVE_W];
                     r_snap_env[v]  <= bus.env_in[v*ENV_W +: ENV_W];
                  end
                  r_snap_mask <= bus.voice_mask;
                  r_idx       <= {IDX_W{1'b0}};
                  r_busy      <= 1'b1;
                  r_state     <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               if (r_idx == LAST_IDX) begin
                  r_idx   <= {IDX_W{1'b0}};
                  r_state <= DRAIN;
               end else begin
                  r_idx   <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                  r_state <= RUN;
               end
            end
            DRAIN: begin
               // Leave as the last product is written so busy falls with done.
               if (w_last_wr) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_state <= DRAIN;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase

         if (w_pvalid) begin
            for (int v = 0; v < VOICES; v++) begin
               r_shadow[v] <= w_merged[v];
            end
         end else begin
            for (int v = 0; v < VOICES; v++) begin
               r_shadow[v] <= r_shadow[v];
            end
         end

         if (w_last_wr) begin
            r_signal_out <= w_merged_flat;
            r_done       <= 1'b1;
         end else begin
            r_signal_out <= r_signal_out;
         end
      end
   end

   assign bus.signal_out = r_signal_out;
   assign bus.done       = r_done;
   assign bus.busy       = r_busy;
   assign bus.overrun    = r_overrun;

endmodule
